axis_packet_mux: RTL and testbench

Two-input AXI-Stream packet multiplexer sitting directly downstream of the down-counter stream sources in the Axis_Mux design. Each slave port carries one counter's data/valid/ready/last stream. The block arbitrates round-robin at packet boundaries and locks onto the granted input until its `last` beat is accepted. It forwards the beats through a one-deep registered output stage.

---
 rtl/axis_mux_pkg.sv | 12 +
 rtl/axis_out_reg.sv | 38 +++
 rtl/axis_packet_mux.sv | 103 ++++++++++
 tb/tb_axis_packet_mux.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mux_pkg.sv
// Shared types and constants for the Axis_Mux stream stages.
package axis_mux_pkg;

    localparam int AXIS_DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } mux_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-deep registered AXI-Stream output stage.
// The owner raises 'load' only when 'load_en' is high, which keeps the
// slot from being overwritten while a beat is stalled downstream.
module axis_out_reg
    import axis_mux_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    assign load_en = !m_valid || m_ready;

    // Capture a new beat, or drop the held one once downstream takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data  <= '0;
            m_last  <= 1'b0;
            m_valid <= 1'b0;
        end else if (load) begin
            m_data  <= load_data;
            m_last  <= load_last;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_packet_mux.sv
// Two-input AXI-Stream packet multiplexer. Arbitrates round-robin at packet
// boundaries, stays locked on the granted input until its last beat is
// accepted, and forwards beats through a registered output stage.
module axis_packet_mux
    import axis_mux_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DW_DEFAULT
) (
    input  logic                  mux_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic                  s0_last,
    input  logic [DATA_WIDTH-1:0] s1_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic                  s1_last,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  mux_sel,
    output logic                  mux_busy,
    output logic [31:0]           pkt_count
);

    mux_state_t            state;
    logic                  last_grant;
    logic                  load_en;
    logic                  load;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

    // Only the locked input sees ready, and only when the output slot can take a beat.
    assign s0_ready = (state == LOCK0) && load_en;
    assign s1_ready = (state == LOCK1) && load_en;
    assign load     = (s0_valid && s0_ready) || (s1_valid && s1_ready);
    assign sel_data = (state == LOCK1) ? s1_data : s0_data;
    assign sel_last = (state == LOCK1) ? s1_last : s0_last;
    assign mux_busy = (state != IDLE);

    // Arbitration and packet lock: grant in IDLE, release after the last beat.
    always_ff @(posedge mux_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            mux_sel    <= 1'b0;
            pkt_count  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_valid && s1_valid) begin
                        if (last_grant) begin
                            state   <= LOCK0;
                            mux_sel <= 1'b0;
                        end else begin
                            state   <= LOCK1;
                            mux_sel <= 1'b1;
                        end
                    end else if (s0_valid) begin
                        state   <= LOCK0;
                        mux_sel <= 1'b0;
                    end else if (s1_valid) begin
                        state   <= LOCK1;
                        mux_sel <= 1'b1;
                    end
                end
                LOCK0: begin
                    if (load && sel_last) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                        pkt_count  <= pkt_count + 32'd1;
                    end
                end
                LOCK1: begin
                    if (load && sel_last) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                        pkt_count  <= pkt_count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk       (mux_clk),
        .reset     (reset),
        .load      (load),
        .load_data (sel_data),
        .load_last (sel_last),
        .load_en   (load_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

endmodule

// File: tb/tb_axis_packet_mux.sv
// Self-checking bench for axis_packet_mux. Sources hold valid while they have
// beats queued, so the expected packet order is plain round-robin over the
// non-empty source queues, starting with input 0 after every reset.
module tb_axis_packet_mux;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        first;
        logic        src;
    } beat_t;

    logic        mux_clk = 1'b0;
    logic        reset;
    logic [31:0] s0_data, s1_data, m_data;
    logic        s0_valid, s0_ready, s0_last;
    logic        s1_valid, s1_ready, s1_last;
    logic        m_valid, m_ready, m_last;
    logic        mux_sel, mux_busy;
    logic [31:0] pkt_count;

    beat_t q0[$];
    beat_t q1[$];
    beat_t exp_q[$];
    int    out_cyc[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc, in_idx, out_idx, lasts_in, n_pkts;
    int stall_from, stall_len;
    bit ready_random, gaps_on;
    logic        prev_in_hs, prev_in_last, prev_stall;
    logic [31:0] prev_in_data, prev_m_data;

    axis_packet_mux #(.DATA_WIDTH(32)) dut (
        .mux_clk   (mux_clk),
        .reset     (reset),
        .s0_data   (s0_data),
        .s0_valid  (s0_valid),
        .s0_ready  (s0_ready),
        .s0_last   (s0_last),
        .s1_data   (s1_data),
        .s1_valid  (s1_valid),
        .s1_ready  (s1_ready),
        .s1_last   (s1_last),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .mux_sel   (mux_sel),
        .mux_busy  (mux_busy),
        .pkt_count (pkt_count)
    );

    always #5 mux_clk = ~mux_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic addPacket(input int n, input int len, input logic [31:0] d0, input logic [31:0] step);
        beat_t       b;
        logic [31:0] d;
        d = d0;
        for (int i = 0; i < len; i++) begin
            b.data  = d;
            b.last  = (i == len - 1);
            b.first = (i == 0);
            b.src   = (n != 0);
            if (n == 0) q0.push_back(b);
            else        q1.push_back(b);
            d = d + step;
        end
    endtask

    // Round-robin over whole packets; input 0 wins the first tie.
    task automatic buildExpected();
        beat_t c0[$];
        beat_t c1[$];
        beat_t b;
        int    ptr;
        int    p;
        bit    done;
        c0  = q0;
        c1  = q1;
        ptr = 0;
        while (c0.size() > 0 || c1.size() > 0) begin
            if (ptr == 0) p = (c0.size() > 0) ? 0 : 1;
            else          p = (c1.size() > 0) ? 1 : 0;
            done = 1'b0;
            while (!done) begin
                b = (p == 0) ? c0.pop_front() : c1.pop_front();
                exp_q.push_back(b);
                done = b.last;
            end
            n_pkts++;
            ptr = 1 - p;
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_m_valid"},   {31'd0, m_valid},  32'd0);
        chk({tag, "_m_data"},    m_data,            32'd0);
        chk({tag, "_m_last"},    {31'd0, m_last},   32'd0);
        chk({tag, "_s0_ready"},  {31'd0, s0_ready}, 32'd0);
        chk({tag, "_s1_ready"},  {31'd0, s1_ready}, 32'd0);
        chk({tag, "_mux_sel"},   {31'd0, mux_sel},  32'd0);
        chk({tag, "_mux_busy"},  {31'd0, mux_busy}, 32'd0);
        chk({tag, "_pkt_count"}, pkt_count,         32'd0);
    endtask

    task automatic newTest();
        reset    = 1'b1;
        s0_valid = 1'b0; s0_data = 32'd0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = 32'd0; s1_last = 1'b0;
        m_ready  = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete(); out_cyc.delete();
        cyc = 0; in_idx = 0; out_idx = 0; lasts_in = 0; n_pkts = 0;
        stall_from = 0; stall_len = 0; ready_random = 1'b0; gaps_on = 1'b0;
        prev_in_hs = 1'b0; prev_stall = 1'b0;
        prev_in_data = 32'd0; prev_in_last = 1'b0; prev_m_data = 32'd0;
        @(negedge mux_clk);
        reset = 1'b0;
    endtask

    task automatic driveInputs();
        if (q0.size() > 0 && !(gaps_on && !q0[0].first && $urandom_range(0, 3) == 0)) begin
            s0_valid = 1'b1; s0_data = q0[0].data; s0_last = q0[0].last;
        end else begin
            s0_valid = 1'b0; s0_data = $urandom; s0_last = 1'($urandom_range(0, 1));
        end
        if (q1.size() > 0 && !(gaps_on && !q1[0].first && $urandom_range(0, 3) == 0)) begin
            s1_valid = 1'b1; s1_data = q1[0].data; s1_last = q1[0].last;
        end else begin
            s1_valid = 1'b0; s1_data = $urandom; s1_last = 1'($urandom_range(0, 1));
        end
        m_ready = !(cyc >= stall_from && cyc < stall_from + stall_len) &&
                  (!ready_random || $urandom_range(0, 3) != 0);
    endtask

    task automatic checkOutput();
        int cur;
        if (prev_in_hs) begin
            chk("latency_valid", {31'd0, m_valid}, 32'd1);
            chk("latency_data",  m_data,           prev_in_data);
            chk("latency_last",  {31'd0, m_last},  {31'd0, prev_in_last});
        end
        if (prev_stall) begin
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_data",  m_data,           prev_m_data);
        end
        if (m_valid && !m_ready)
            chk("backpressure_ready", {30'd0, s0_ready, s1_ready}, 32'd0);
        chk("pkt_count", pkt_count, 32'(lasts_in));
        cur = (in_idx < exp_q.size()) ? int'(exp_q[in_idx].src) : 2;
        if (s0_ready) begin
            chk("grant_src0", 32'(cur), 32'd0);
            chk("sel_src0",   {31'd0, mux_sel},  32'd0);
            chk("busy_src0",  {31'd0, mux_busy}, 32'd1);
        end
        if (s1_ready) begin
            chk("grant_src1", 32'(cur), 32'd1);
            chk("sel_src1",   {31'd0, mux_sel},  32'd1);
            chk("busy_src1",  {31'd0, mux_busy}, 32'd1);
        end
        prev_in_hs = 1'b0;
        if (s0_valid && s0_ready) begin
            prev_in_hs = 1'b1; prev_in_data = s0_data; prev_in_last = s0_last;
            void'(q0.pop_front());
            in_idx++;
            if (s0_last) lasts_in++;
        end
        if (s1_valid && s1_ready) begin
            prev_in_hs = 1'b1; prev_in_data = s1_data; prev_in_last = s1_last;
            void'(q1.pop_front());
            in_idx++;
            if (s1_last) lasts_in++;
        end
        if (m_valid && m_ready) begin
            if (out_idx < exp_q.size()) begin
                chk("out_data", m_data, exp_q[out_idx].data);
                chk("out_last", {31'd0, m_last}, {31'd0, exp_q[out_idx].last});
                out_cyc.push_back(cyc);
            end else begin
                chk("out_beat_count", 32'(out_idx + 1), 32'(exp_q.size()));
            end
            out_idx++;
        end
        prev_stall  = m_valid && !m_ready;
        prev_m_data = m_data;
    endtask

    // Run the engine until every expected beat has left, or stop early after stop_in input beats.
    task automatic applyStimulus(input int budget, input int stop_in);
        int t    = 0;
        int tail = 0;
        while (t < budget) begin
            if (stop_in > 0 && in_idx >= stop_in) break;
            if (out_idx >= exp_q.size() && in_idx >= exp_q.size()) begin
                tail++;
                if (tail > 3) break;
            end
            @(negedge mux_clk);
            cyc++;
            t++;
            driveInputs();
            #1;
            checkOutput();
        end
        if (stop_in == 0) chk("beats_out", 32'(out_idx), 32'(exp_q.size()));
    endtask

    // With m_ready held high: back-to-back beats inside a packet, one bubble between packets.
    task automatic checkTiming(input string tag);
        for (int i = 1; i < out_cyc.size() && i < exp_q.size(); i++)
            chk({tag, "_gap"}, 32'(out_cyc[i] - out_cyc[i-1]), exp_q[i].first ? 32'd2 : 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset    = 1'b1;
        s0_valid = 1'b0; s0_data = 32'd0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = 32'd0; s1_last = 1'b0;
        m_ready  = 1'b0;
        #2;
        checkReset("reset");

        $display("[TB] 3-beat packet on input 0");
        newTest();
        addPacket(0, 3, 32'h000000A0, 32'd1);
        buildExpected();
        applyStimulus(200, 0);
        chk("A_first_out_cycle", 32'(out_cyc.size() > 0 ? out_cyc[0] : -1), 32'd3);
        checkTiming("A");
        chk("A_pkt_count", pkt_count, 32'd1);
        chk("A_mux_sel", {31'd0, mux_sel}, 32'd0);

        $display("[TB] both inputs, alternating 2-beat packets");
        newTest();
        addPacket(0, 2, 32'h0000B000, 32'd1);
        addPacket(0, 2, 32'h0000B100, 32'd1);
        addPacket(1, 2, 32'h0000C000, 32'd1);
        addPacket(1, 2, 32'h0000C100, 32'd1);
        buildExpected();
        applyStimulus(200, 0);
        checkTiming("B");
        chk("B_pkt_count", pkt_count, 32'd4);

        $display("[TB] back-pressure mid-packet");
        newTest();
        addPacket(0, 4, 32'h000000D0, 32'd1);
        stall_from = 4;
        stall_len  = 3;
        buildExpected();
        applyStimulus(200, 0);
        chk("C_pkt_count", pkt_count, 32'd1);

        $display("[TB] input 1 last while input 0 locked");
        newTest();
        addPacket(0, 3, 32'h000000E0, 32'd1);
        addPacket(1, 1, 32'h000000F0, 32'd0);
        buildExpected();
        applyStimulus(200, 0);
        chk("D_pkt_count", pkt_count, 32'd2);
        chk("D_mux_sel", {31'd0, mux_sel}, 32'd1);

        $display("[TB] reset during a 4-beat packet");
        newTest();
        addPacket(0, 4, 32'h00000050, 32'd1);
        buildExpected();
        applyStimulus(100, 2);
        @(posedge mux_clk);
        #2;
        reset = 1'b1;
        #1;
        checkReset("midreset");
        newTest();
        addPacket(0, 4, 32'h00000060, 32'd1);
        buildExpected();
        applyStimulus(200, 0);
        chk("E_pkt_count", pkt_count, 32'd1);

        $display("[TB] down-counter packet near wrap");
        newTest();
        ready_random = 1'b1;
        addPacket(0, 4, 32'hFFFFFFFF, 32'hFFFFFFFF);
        buildExpected();
        applyStimulus(300, 0);
        chk("F_pkt_count", pkt_count, 32'd1);

        $display("[TB] randomized packets with stalls and valid gaps");
        newTest();
        ready_random = 1'b1;
        gaps_on      = 1'b1;
        for (int k = 0; k < 8; k++)
            addPacket(0, $urandom_range(1, 5), $urandom, $urandom);
        for (int k = 0; k < 6; k++)
            addPacket(1, $urandom_range(1, 5), $urandom, $urandom);
        buildExpected();
        applyStimulus(3000, 0);
        chk("G_pkt_count", pkt_count, 32'(n_pkts));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
